tmds_pll_sequencer: RTL
=======================

TMDS_PLL_SEQUENCER -- requirements
Module: tmds_pll_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_CYCLES, default 27: pll_reset pulse length in clkin cycles (min 1).
REQ-002 The block SHALL have parameter LOCK_STABLE_CYCLES, default 2700: consecutive synchronized-lock cycles required before release (min 1).
REQ-003 The block SHALL have parameter LOCK_TIMEOUT_CYCLES, default 270000: WAIT_LOCK cycles allowed before a retry (min 1).
REQ-004 The block SHALL have parameter MAX_RETRIES, default 3: failed lock attempts tolerated before FAULT (0..15).
REQ-005 clkin  input  1  27 MHz free-running reference clock; the only clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  level; 1 requests a running TMDS clock, 0 requests shutdown.
REQ-008 pll_lock  input  1  PLL lock flag, asynchronous to clkin.
REQ-009 pll_reset  output  1  PLL RESET drive, active-high.
REQ-010 hdmi_rst  output  1  active-high reset for the TMDS serializer domain.
REQ-011 ready  output  1  1 while the TMDS clock is locked and released.
REQ-012 lock_lost  output  1  one-cycle pulse on lock loss in RUN.
REQ-013 fault  output  1  1 while in FAULT.
REQ-014 retry_count  output  4  failed lock attempts since the last entry to RUN or IDLE.

Function
REQ-015 pll_lock SHALL pass through a 2-flop synchronizer (lock_s); all decisions use lock_s, so added latency is 2 cycles.
REQ-016 All outputs SHALL be registered; a state's outputs appear in the cycle after the transition into it.
REQ-017 States SHALL be IDLE, PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT, with one shared cycle counter cleared on every state entry.
REQ-018 IDLE: pll_reset=1, hdmi_rst=1, ready=0; retry_count=0; enable=1 -> PLL_RST.
REQ-019 PLL_RST: pll_reset=1, hdmi_rst=1; after RESET_CYCLES cycles -> WAIT_LOCK.
REQ-020 WAIT_LOCK: pll_reset=0, hdmi_rst=1; lock_s=1 -> STABLE; counter reaching LOCK_TIMEOUT_CYCLES with lock_s=0 -> retry.
REQ-021 Retry: if retry_count==MAX_RETRIES -> FAULT; otherwise retry_count+1 and -> PLL_RST.
REQ-022 retry_count SHALL saturate at 15 and never wrap.
REQ-023 STABLE: pll_reset=0, hdmi_rst=1; lock_s=0 -> WAIT_LOCK with a fresh timeout and no retry increment; LOCK_STABLE_CYCLES consecutive lock_s=1 cycles -> RUN.
REQ-024 RUN: hdmi_rst=0, ready=1, retry_count=0.
REQ-025 In RUN, lock_s=0 SHALL produce lock_lost=1 for exactly one cycle, hdmi_rst=1, ready=0, and -> PLL_RST.
REQ-026 FAULT: pll_reset=1, hdmi_rst=1, fault=1; exit only via enable=0 -> IDLE, which clears fault.
REQ-027 enable=0 in any state SHALL force IDLE on the next edge; this overrides every other transition, and lock_lost SHALL NOT pulse.
REQ-028 If lock drops in the same cycle the stable count completes, the drop SHALL win (-> WAIT_LOCK).

Reset
REQ-029 reset=1 SHALL force IDLE on the next edge from any state, even mid-operation, with pll_reset=1, hdmi_rst=1, ready=0, lock_lost=0, fault=0, retry_count=0, counter=0, and synchronizer flops=0.
REQ-030 reset SHALL take priority over enable and all lock events.

Verification (RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2)
REQ-031 Nominal: reset, then enable=1; pll_lock=1 from cycle 10 -> pll_reset high exactly 4 cycles; ready=1 and hdmi_rst=0 only after 8 consecutive lock_s cycles (2-cycle sync included); retry_count=0.
REQ-032 Timeout path: enable=1, pll_lock=0 forever -> three PLL_RST pulses; retry_count goes 0,1,2; then fault=1 with pll_reset=1. After enable=0 -> IDLE with fault=0 and retry_count=0.
REQ-033 Glitch in STABLE: lock high 5 cycles, low 1, then high -> no ready until 8 fresh consecutive cycles; retry_count unchanged.
REQ-034 Loss in RUN: drop pll_lock -> lock_lost is a single 1-cycle pulse 3 cycles later, ready=0, hdmi_rst=1, pll_reset re-pulses for 4 cycles, then relock returns to RUN.
REQ-035 Asserting reset mid-WAIT_LOCK with retry_count=1 -> all outputs at reset values next cycle; enable still 1 -> PLL_RST restarts from count 0.

Source files
------------

// File: rtl/tmds_pll_sequencer.sv
// Power-up / relock sequencer for the TMDS PLL: pulses PLL reset, waits for a
// stable lock, releases the serializer domain and retries or faults on timeout.
module tmds_pll_sequencer #(
  parameter int RESET_CYCLES        = 27,
  parameter int LOCK_STABLE_CYCLES  = 2700,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       enable,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       hdmi_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic       fault,
  output logic [3:0] retry_count
);

  localparam int MAX_A     = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_LIMIT = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W     = $clog2(MAX_LIMIT + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [3:0]       retry_next;
  logic             lost_next;
  logic             lock_meta, lock_s;

  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_next = state;
    retry_next = retry_count;
    lost_next  = 1'b0;

    case (state)
      S_IDLE:      state_next = S_PLL_RST;
      S_PLL_RST: begin
        if (count == RST_LAST) state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = S_STABLE;
        end else if (count == TIMEOUT_LAST) begin
          if (retry_count == RETRY_LIMIT) begin
            state_next = S_FAULT;
          end else begin
            state_next = S_PLL_RST;
            if (retry_count != 4'hF) retry_next = retry_count + 4'd1;
          end
        end
      end
      // A lock drop beats a completing stable count.
      S_STABLE: begin
        if (!lock_s)                    state_next = S_WAIT_LOCK;
        else if (count == STABLE_LAST)  state_next = S_RUN;
      end
      S_RUN: begin
        if (!lock_s) begin
          state_next = S_PLL_RST;
          lost_next  = 1'b1;
        end
      end
      S_FAULT:     state_next = S_FAULT;
      default:     state_next = S_IDLE;
    endcase

    if (!enable) begin
      state_next = S_IDLE;
      lost_next  = 1'b0;
    end

    if (state_next == S_IDLE || state_next == S_RUN) retry_next = 4'd0;

    // The shared counter restarts on every state entry and only runs in timed states.
    if (state_next != state)
      count_next = '0;
    else if (state == S_PLL_RST || state == S_WAIT_LOCK || state == S_STABLE)
      count_next = count + CNT_W'(1);
    else
      count_next = count;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state       <= S_IDLE;
      count       <= '0;
      retry_count <= 4'd0;
      pll_reset   <= 1'b1;
      hdmi_rst    <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      retry_count <= retry_next;
      pll_reset   <= (state_next inside {S_IDLE, S_PLL_RST, S_FAULT});
      hdmi_rst    <= (state_next != S_RUN);
      ready       <= (state_next == S_RUN);
      lock_lost   <= lost_next;
      fault       <= (state_next == S_FAULT);
    end
  end

endmodule
